// File: rtl/fp8_encode.sv
// Sequential int8 -> fp8 {S, E[2:0], F[3:0]} encoder, normalizing one bit per clock.
// Optional FP8_NEG_INV_FRAC_EN: store F bitwise inverted for negative results.
module fp8_encode (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic [7:0] res,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic       r_sign;
  logic [8:0] r_mag;
  logic [3:0] r_exp;

  logic [8:0] w_absIn;
  logic       w_normDone;
  logic [3:0] w_frac;
  logic [7:0] w_packed;
  logic       w_sat;

  // Nine bits so that -128 keeps its magnitude of 128.
  always_comb begin
    w_absIn = {1'b0, din};
    if (din[7]) begin
      w_absIn = 9'd0 - {din[7], din};
    end
  end

  assign w_normDone = (r_mag == 9'd0) || r_mag[7];

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = NORM;
      NORM:    if (w_normDone) w_nextState = PACK;
      PACK:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

`ifdef FP8_NEG_INV_FRAC_EN
  assign w_frac = r_sign ? ~r_mag[7:4] : r_mag[7:4];
`else
  assign w_frac = r_mag[7:4];
`endif

  // Only -128 reaches PACK with the exponent still at 8.
  always_comb begin
    w_packed = {r_sign, r_exp[2:0], w_frac};
    w_sat    = 1'b0;
    if (r_mag == 9'd0) begin
      w_packed = 8'h00;
    end else if (r_exp == 4'd8) begin
      w_sat = 1'b1;
`ifdef FP8_NEG_INV_FRAC_EN
      w_packed = 8'hF0;
`else
      w_packed = 8'hFF;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign <= 1'b0;
      r_mag  <= 9'd0;
      r_exp  <= 4'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      res    <= 8'h00;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sign <= din[7];
            r_mag  <= w_absIn;
            r_exp  <= 4'd8;
            busy   <= 1'b1;
          end
        end
        NORM: begin
          if (!w_normDone) begin
            r_mag <= r_mag << 1;
            r_exp <= r_exp - 4'd1;
          end
        end
        PACK: begin
          res  <= w_packed;
          ovf  <= w_sat;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp8_encode.sv
// Scoreboard bench for fp8_encode: randomized and directed conversions against an arithmetic model.
module tb_fp8_encode;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] din;
  logic       busy;
  logic       done;
  logic [7:0] res;
  logic       ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] din;
    logic [7:0] res;
    logic       ovf;
    int         doneCyc;
  } exp_t;

  exp_t sb[$];

  fp8_encode dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .res   (res),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: value = 0.F * 2^E, so E is the bit length of |din| and F its top four bits.
  function automatic exp_t model(input logic [7:0] d, input int t0);
    exp_t r;
    int v, a, e, f, k;
    bit neg;
    v   = int'($signed(d));
    neg = (v < 0);
    a   = neg ? -v : v;
    r.din = d;
    r.ovf = 1'b0;
    k = 0;
    if (a == 0) begin
      r.res = 8'h00;
    end else if (a == 128) begin
      r.ovf = 1'b1;
`ifdef FP8_NEG_INV_FRAC_EN
      r.res = 8'hF0;
`else
      r.res = 8'hFF;
`endif
    end else begin
      e = 0;
      while ((1 << e) <= a) e++;
      k = 8 - e;
      f = (a * (1 << k)) / 16;
`ifdef FP8_NEG_INV_FRAC_EN
      if (neg) f = 15 - f;
`endif
      r.res = 8'((neg ? 128 : 0) + e * 16 + f);
    end
    r.doneCyc = t0 + k + 2;
    return r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput($sformatf("res_din%02h", e.din), int'(res), int'(e.res));
        checkOutput($sformatf("ovf_din%02h", e.din), int'(ovf), int'(e.ovf));
        checkOutput($sformatf("latency_din%02h", e.din), cyc, e.doneCyc);
      end
    end
  end

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) checkOutput("idle_timeout", int'(busy), 0);
  endtask

  // Issue one request; optionally keep start high (with scrambled din) while busy.
  task automatic applyStimulus(input logic [7:0] d, input int extraHold);
    waitIdle();
    din   = d;
    start = 1'b1;
    sb.push_back(model(d, cyc + 1));
    @(negedge clk);
    checkOutput("busy_after_accept", int'(busy), 1);
    for (int i = 0; i < extraHold; i++) begin
      din = 8'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    din   = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_res", int'(res), 0);
    checkOutput("reset_ovf", int'(ovf), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    rst = 1'b0;

    applyStimulus(8'h05, 0);
    applyStimulus(8'h7F, 0);
    applyStimulus(8'hFB, 0);
    applyStimulus(8'h80, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h01, 3);
    applyStimulus(8'h40, 0);
    applyStimulus(8'hC0, 0);
    applyStimulus(8'hFF, 0);
    waitIdle();
    repeat (2) @(negedge clk);

    // Abort a conversion with reset: outputs clear at once and no done follows.
    applyStimulus(8'h01, 3);
    rst = 1'b1;
    sb.delete();
    #1;
    checkOutput("abort_res", int'(res), 0);
    checkOutput("abort_ovf", int'(ovf), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'($urandom), int'($urandom_range(0, 1)));
    end
    waitIdle();
    repeat (4) @(negedge clk);
    checkOutput("pending_results", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
